// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer:
// operation codes, FSM states and the divide-by-zero quotient pattern.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ITER  = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_addsub.sv
// Single combinational adder/subtractor shared by every iteration of the sequencer.
// sub=1 computes x + ~y + 1, so cout=1 means no borrow.
module muldiv_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] y_eff;

    assign y_eff = sub ? ~y : y;
    assign full  = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    assign s     = full[WIDTH-1:0];
    assign cout  = full[WIDTH];

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: shift-add multiply and restoring
// divide over WIDTH iterations of one shared add/sub unit, results in hi/lo.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    state_e               state, state_nxt;
    op_e                  op_r;
    logic [WIDTH-1:0]     a_r, b_r;
    logic [2*WIDTH-1:0]   p;
    logic [WIDTH-1:0]     m;
    logic [CNT_W-1:0]     cnt;
    logic                 neg_q, neg_r;
    logic [WIDTH-1:0]     hi_r, lo_r;
    logic                 div_zero_r;

    logic                 is_div, is_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   p_neg;
    logic [WIDTH-1:0]     hi_neg, lo_neg;
    logic [WIDTH-1:0]     as_x, as_s;
    logic                 as_cout;
    logic                 div_take;

    assign is_div    = (op_r == OP_DIVU) || (op_r == OP_DIV);
    assign is_signed = (op_r == OP_MULT) || (op_r == OP_DIV);

    // Magnitude of the most negative value wraps to itself and is then treated as unsigned.
    assign a_mag = (is_signed && a_r[WIDTH-1]) ? (~a_r + WIDTH'(1)) : a_r;
    assign b_mag = (is_signed && b_r[WIDTH-1]) ? (~b_r + WIDTH'(1)) : b_r;

    // Sign fix-up uses its own incrementers so the add/sub unit stays iteration-only.
    assign p_neg  = ~p + (2*WIDTH)'(1);
    assign hi_neg = ~p[2*WIDTH-1:WIDTH] + WIDTH'(1);
    assign lo_neg = ~p[WIDTH-1:0] + WIDTH'(1);

    // Divide works on P shifted left by one; multiply adds into the upper half directly.
    assign as_x = is_div ? p[2*WIDTH-2:WIDTH-1] : p[2*WIDTH-1:WIDTH];

    muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x    (as_x),
        .y    (m),
        .sub  (is_div),
        .s    (as_s),
        .cout (as_cout)
    );

    // The bit shifted out of the partial remainder is the 33rd bit of the
    // minuend; when set, the subtraction always succeeds even if cout is 0.
    assign div_take = p[2*WIDTH-1] | as_cout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SETUP;
            S_SETUP: state_nxt = (is_div && (b_r == '0)) ? S_DONE : S_ITER;
            S_ITER:  if (cnt == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every datapath register is reset, so an aborted operation leaves no stale result on hi/lo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r       <= OP_MULTU;
            a_r        <= '0;
            b_r        <= '0;
            p          <= '0;
            m          <= '0;
            cnt        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
            div_zero_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r       <= op_e'(op);
                        a_r        <= a;
                        b_r        <= b;
                        div_zero_r <= 1'b0;
                    end
                end
                S_SETUP: begin
                    neg_q <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    neg_r <= is_signed & a_r[WIDTH-1];
                    p     <= {{WIDTH{1'b0}}, a_mag};
                    m     <= b_mag;
                    cnt   <= '1;
                    if (is_div && (b_r == '0)) begin
                        div_zero_r <= 1'b1;
                        hi_r       <= a_r;
                        lo_r       <= DIV0_LO;
                    end
                end
                S_ITER: begin
                    if (is_div) begin
                        if (div_take) p <= {as_s, p[WIDTH-2:0], 1'b1};
                        else          p <= {p[2*WIDTH-2:0], 1'b0};
                    end else begin
                        if (p[0]) p <= {as_cout, as_s, p[WIDTH-1:1]};
                        else      p <= {1'b0, p[2*WIDTH-1:WIDTH], p[WIDTH-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    if (is_div) begin
                        hi_r <= neg_r ? hi_neg : p[2*WIDTH-1:WIDTH];
                        lo_r <= neg_q ? lo_neg : p[WIDTH-1:0];
                    end else if (neg_q) begin
                        hi_r <= p_neg[2*WIDTH-1:WIDTH];
                        lo_r <= p_neg[WIDTH-1:0];
                    end else begin
                        hi_r <= p[2*WIDTH-1:WIDTH];
                        lo_r <= p[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign div_zero = div_zero_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: table of operations with hand-computed
// results and latencies, plus held-start and mid-operation reset sequences.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_checks;
    int n_fail;

    muldiv_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation at cycle 0 and follow it to its done pulse.
    task automatic run_op(input vec_t v, input string tag);
        int          lat;
        logic        busy_bad;
        logic [31:0] h, l;
        logic        dz;
        lat = -1; busy_bad = 1'b0; h = '0; l = '0; dz = 1'b0;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(negedge clk);
            if (!busy) busy_bad = 1'b1;
            if (done) begin
                lat = c; h = hi; l = lo; dz = div_zero;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(v.lat));
        check({tag, " hi"}, 64'(h), 64'(v.hi));
        check({tag, " lo"}, 64'(l), 64'(v.lo));
        check({tag, " div_zero"}, 64'(dz), 64'(v.dz));
        check({tag, " busy through op"}, 64'(busy_bad), 64'd0);
        @(negedge clk);
        check({tag, " idle after done"}, {62'd0, busy, done}, 64'd0);
        check({tag, " result held"}, {hi, lo}, {v.hi, v.lo});
    endtask

    initial begin
        int          first_done, second_done;
        logic [31:0] h1, l1, h2, l2;
        logic        busy36;
        logic        saw_done;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35};
        vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35};
        vecs[3]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 35};
        vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35};
        vecs[5]  = '{2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2};
        vecs[6]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 35};
        vecs[7]  = '{2'b01, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 35};
        vecs[8]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 35};
        vecs[9]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0, 35};
        vecs[10] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 35};
        vecs[11] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle hold busy", 64'(busy), 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start held high; operands change mid-operation and must be ignored
        first_done = -1; second_done = -1; busy36 = 1'b1;
        h1 = '0; l1 = '0; h2 = '0; l2 = '0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
        for (int c = 1; c <= 120 && second_done < 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                op = 2'b10; a = 32'd100; b = 32'd7;
            end
            if (c == 37) start = 1'b0;
            @(negedge clk);
            if (c == 36) busy36 = busy;
            if (done) begin
                if (first_done < 0) begin
                    first_done = c; h1 = hi; l1 = lo;
                end else begin
                    second_done = c; h2 = hi; l2 = lo;
                end
            end
        end
        start = 1'b0;
        check("held start first latency", 64'(first_done), 64'd35);
        check("held start first result", {h1, l1}, {32'd0, 32'd15});
        check("held start idle gap busy", 64'(busy36), 64'd0);
        check("held start second latency", 64'(second_done), 64'd71);
        check("held start second result", {h2, l2}, {32'd2, 32'd14});

        // reset pulsed at cycle 10 of DIVU 100/7
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort busy immediate", 64'(busy), 64'd0);
        check("abort hi/lo immediate", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort no done", 64'(saw_done), 64'd0);

        run_op('{2'b00, 32'd12, 32'd12, 32'd0, 32'd144, 1'b0, 35}, "after abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer for the CPU execute stage. It handles MULT, MULTU, DIV and DIVU.
- It time-shares one 32-bit add/sub unit across 32 iterations: shift-add for multiply, restoring subtract for divide.
- Results land in HI/LO-style registers.
- The pipeline controller starts an operation with a start/busy/done handshake and stalls on busy.

Parameters:
- WIDTH, 32, operand width; ITER count equals WIDTH. Only 32 is verified.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; captured with start
- a  in  32  multiplicand / dividend; captured with start
- b  in  32  multiplier / divisor; captured with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; hi/lo valid in that cycle
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- div_zero  out  1  registered flag, set on a divide with b==0; cleared by the next accepted start

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; counter and working registers cleared.
  - Reset asserted mid-operation aborts it. No done is produced and hi/lo read 0.
- States are IDLE, SETUP, ITER, FIX, DONE.
- IDLE:
  - start=1 captures op, a, b and goes to SETUP.
  - start=0 holds. hi/lo keep the last result indefinitely.
- SETUP (1 cycle):
  - Signed ops: take magnitudes of a and b. Record neg_q=a[31]^b[31] and neg_r=a[31]. Unsigned ops: record both as 0.
  - Load accumulator P={32'b0, |a|}, operand M=|b|, counter=31.
  - Divide with M==0: set div_zero, hi=a (raw), lo=32'hFFFFFFFF, go to DONE (skip ITER/FIX).
  - Otherwise go to ITER.
- ITER (exactly 32 cycles), one add/sub per cycle:
  - Multiply:
    - If P[0]==1: sum={carry, P[63:32]+M}. Otherwise sum={1'b0, P[63:32]}.
    - P = {sum, P[31:1]}. The 33-bit sum keeps the carry.
  - Divide:
    - Shift P left 1.
    - diff = P[63:32] - M with borrow (add ~M with cin=1).
    - If no borrow (carry out =1): P[63:32]=diff and P[0]=1. Otherwise restore and P[0]=0.
  - Counter decrements. At counter==0, go to FIX.
- FIX (1 cycle):
  - MULT with neg_q: negate the 64-bit P (two's complement).
  - DIV: negate quotient P[31:0] if neg_q; negate remainder P[63:32] if neg_r.
  - Write hi=P[63:32] and lo=P[31:0], then go to DONE.
- DONE (1 cycle): done=1, busy=1, then go to IDLE.
- start is ignored while not in IDLE, so back-to-back operations need start in the cycle after DONE.
- Latency from the start cycle (cycle 0):
  - Normal: done at cycle 35.
  - Divide by zero: done at cycle 2.
- Arithmetic rules:
  - All arithmetic wraps modulo 2^32 per half.
  - DIV 0x80000000 / -1 gives lo=0x80000000, hi=0. No trap and no flag.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- The add/sub unit is used only in ITER. FIX negation uses a separate incrementer.

Decomposition:
- Shared package holds:
  - op encodings OP_MULTU, OP_MULT, OP_DIVU, OP_DIV
  - state encodings S_IDLE..S_DONE (3-bit)
  - constant DIV0_LO = 32'hFFFFFFFF
- Sub-module muldiv_addsub: 32-bit combinational add/sub.
  - Inputs: x, y, sub. Outputs: s (32), cout.
  - sub inverts y and sets cin=1.
  - The sequencer instantiates it once.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at cycle 35; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1-35.
- MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=7 -> lo=14, hi=2. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234 b=0 -> done at cycle 2, div_zero=1, hi=0x1234, lo=0xFFFFFFFF. The next accepted start clears div_zero.
- Start held high through a MULTU with a new op/operands presented mid-operation -> ignored; the result matches the original operands, and the second op is accepted only at the IDLE cycle after DONE.
- Reset pulsed at cycle 10 of DIVU 100/7 -> busy=0 and hi=lo=0 immediately (asynchronously); no done pulse; a fresh op afterwards computes correctly.
